// File: rtl/ifft_pkg.sv
// Shared types and helpers for the in-place radix-2 inverse FFT engine.
// Defaults describe the 8-point, 32-bit-word configuration.
package ifft_pkg;

    localparam int DEF_SAMPLES = 8;
    localparam int DEF_WIDTH   = 32;
    localparam int LOG2N       = $clog2(DEF_SAMPLES);
    localparam int FRAC        = DEF_WIDTH / 2 - 2;

    typedef struct packed {
        logic signed [DEF_WIDTH/2-1:0] re;
        logic signed [DEF_WIDTH/2-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        UNLOAD
    } state_t;

    // Reverses the low 'bits' bits of idx.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int bits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < bits; i++) r = {r[30:0], idx[i]};
        return r;
    endfunction

    // Clamps a signed value to the range of a 'width'-bit signed number.
    function automatic logic signed [31:0] sat(input logic signed [31:0] value, input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/ifft_engine_if.sv
// Frame load/unload streams of the inverse FFT engine.
// master is the frame producer/consumer side, slave is the engine.
interface ifft_engine_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/ifft_twiddle_rom.sv
// Conjugate twiddle table: idx t -> {cos(2*pi*t/N), +sin(2*pi*t/N)} in Q(FRAC).
// Entries are computed at elaboration and rounded to nearest.
module ifft_twiddle_rom #(
    parameter int SAMPLES = 8,
    parameter int WIDTH   = 32,
    parameter int FRAC    = WIDTH / 2 - 2
) (
    input  logic [$clog2(SAMPLES)-2:0] idx,
    output logic signed [WIDTH/2-1:0]  w_re,
    output logic signed [WIDTH/2-1:0]  w_im
);
    localparam real PI    = 3.14159265358979323846;
    localparam real SCALE = real'(1 << FRAC);

    logic signed [WIDTH/2-1:0] cos_tab [SAMPLES/2];
    logic signed [WIDTH/2-1:0] sin_tab [SAMPLES/2];

    for (genvar i = 0; i < SAMPLES / 2; i++) begin : g_tab
        localparam real ANG = 2.0 * PI * real'(i) / real'(SAMPLES);
        localparam int  C   = int'($cos(ANG) * SCALE);
        localparam int  S   = int'($sin(ANG) * SCALE);
        assign cos_tab[i] = (WIDTH/2)'(C);
        assign sin_tab[i] = (WIDTH/2)'(S);
    end

    assign w_re = cos_tab[idx];
    assign w_im = sin_tab[idx];
endmodule

// File: rtl/ifft_engine.sv
// Sequential in-place radix-2 DIT inverse FFT with one time-shared butterfly.
// Frames are loaded bit-reversed, transformed with a /2 per stage, and unloaded in order.
module ifft_engine
    import ifft_pkg::*;
#(
    parameter int SAMPLES = DEF_SAMPLES,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int FRAC    = WIDTH / 2 - 2
) (
    input  logic         clk,
    input  logic         reset_n,
    ifft_engine_if.slave bus,
    output logic         busy
);
    localparam int H     = WIDTH / 2;
    localparam int LOGN  = $clog2(SAMPLES);
    localparam int S_W   = $clog2(LOGN);
    localparam int B_W   = LOGN - 1;
    localparam int SUM_W = H + 2;
    localparam int PRD_W = 2 * H + 1;

    state_t state, state_next;

    logic [LOGN-1:0] k, n, n_inc;
    logic [S_W-1:0]  s;
    logic [B_W-1:0]  b;
    logic            in_fire, out_fire, last_bfly;

    logic [LOGN-1:0]         mask, top, bot;
    logic [B_W-1:0]          tw_idx;
    logic signed [H-1:0]     w_re, w_im, a_re, a_im, b_re, b_im;
    logic signed [2*H-1:0]   m_rr, m_ii, m_ri, m_ir;
    logic signed [PRD_W-1:0] p_re_full, p_im_full;
    logic signed [SUM_W-1:0] p_re, p_im;
    logic signed [H-1:0]     top_re, top_im, bot_re, bot_im;

    logic signed [H-1:0] frame_re [SAMPLES];
    logic signed [H-1:0] frame_im [SAMPLES];

    // Floor-halve (arithmetic shift) then clamp to the H-bit signed range.
    function automatic logic signed [H-1:0] halve_sat(input logic signed [SUM_W-1:0] v);
        return H'(sat(32'(v >>> 1), H));
    endfunction

    ifft_twiddle_rom #(
        .SAMPLES (SAMPLES),
        .WIDTH   (WIDTH),
        .FRAC    (FRAC)
    ) u_rom (
        .idx  (tw_idx),
        .w_re (w_re),
        .w_im (w_im)
    );

    assign in_fire   = bus.in_valid && (state == LOAD);
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign last_bfly = (s == S_W'(LOGN - 1)) && (b == '1);
    assign n_inc     = n + LOGN'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE:    state_next = LOAD;
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && (k == '1)) state_next = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (last_bfly) state_next = UNLOAD;
            end
            UNLOAD:  if (out_fire && (n == '1)) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Butterfly addressing: top = ((b >> s) << (s+1)) | j, bot = top + 2^s.
    always_comb begin
        mask      = (LOGN'(1) << s) - LOGN'(1);
        top       = ((LOGN'(b) & ~mask) << 1) | (LOGN'(b) & mask);
        bot       = top | (mask + LOGN'(1));
        tw_idx    = B_W'((LOGN'(b) & mask) << (LOGN - 1 - int'(s)));
        a_re      = frame_re[top];
        a_im      = frame_im[top];
        b_re      = frame_re[bot];
        b_im      = frame_im[bot];
        m_rr      = (2*H)'(w_re) * (2*H)'(b_re);
        m_ii      = (2*H)'(w_im) * (2*H)'(b_im);
        m_ri      = (2*H)'(w_re) * (2*H)'(b_im);
        m_ir      = (2*H)'(w_im) * (2*H)'(b_re);
        p_re_full = PRD_W'(m_rr) - PRD_W'(m_ii);
        p_im_full = PRD_W'(m_ri) + PRD_W'(m_ir);
        p_re      = SUM_W'(p_re_full >>> FRAC);
        p_im      = SUM_W'(p_im_full >>> FRAC);
        top_re    = halve_sat(SUM_W'(a_re) + p_re);
        top_im    = halve_sat(SUM_W'(a_im) + p_im);
        bot_re    = halve_sat(SUM_W'(a_re) - p_re);
        bot_im    = halve_sat(SUM_W'(a_im) - p_im);
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k             <= '0;
            s             <= '0;
            b             <= '0;
            n             <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            if (in_fire) k <= k + LOGN'(1);
            if (state == COMPUTE) begin
                b <= b + B_W'(1);
                if (b == '1) s <= last_bfly ? '0 : s + S_W'(1);
            end
            if (state == UNLOAD) begin
                if (!bus.out_valid) begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= {frame_re[n], frame_im[n]};
                    bus.out_last  <= (n == '1);
                end else if (bus.out_ready) begin
                    if (n == '1) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        n             <= '0;
                    end else begin
                        n             <= n_inc;
                        bus.out_data  <= {frame_re[n_inc], frame_im[n_inc]};
                        bus.out_last  <= (n_inc == '1);
                    end
                end
            end
        end
    end

    // NOTE: the frame buffer has no reset; LOAD writes every word before COMPUTE reads it.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            frame_re[LOGN'(bitrev(32'(k), LOGN))] <= bus.in_data[WIDTH-1:H];
            frame_im[LOGN'(bitrev(32'(k), LOGN))] <= bus.in_data[H-1:0];
        end else if (state == COMPUTE) begin
            frame_re[top] <= top_re;
            frame_im[top] <= top_im;
            frame_re[bot] <= bot_re;
            frame_im[bot] <= bot_im;
        end
    end
endmodule

// File: tb/tb_ifft_engine.sv
// Self-checking bench for ifft_engine: table vectors, corner-case sequences,
// and random frames checked against a direct inverse DFT computed in reals.
module tb_ifft_engine;
    import ifft_pkg::*;

    localparam int  N  = 8;
    localparam int  W  = 32;
    localparam real PI = 3.14159265358979323846;

    typedef cplx_t [N-1:0] frame_t;
    typedef struct packed {
        frame_t     x_in;
        frame_t     x_exp;
        logic [3:0] tol;
    } vec_t;

    logic   clk     = 1'b0;
    logic   reset_n = 1'b1;
    logic   busy;
    int     n_checks = 0;
    int     n_errors = 0;
    frame_t stim, got, expv;
    vec_t   vecs [3];

    ifft_engine_if #(.WIDTH(W)) bus ();

    ifft_engine #(.SAMPLES(N), .WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic cplx_t mk(input int re, input int im);
        cplx_t c;
        c.re = 16'(re);
        c.im = 16'(im);
        return c;
    endfunction

    // x[n] = (1/N) * sum_k X[k] * exp(+j*2*pi*k*n/N), rounded to nearest.
    function automatic frame_t ref_idft(input frame_t x);
        frame_t y;
        real sr, si, ang, xr, xi;
        for (int n = 0; n < N; n++) begin
            sr = 0.0;
            si = 0.0;
            for (int k = 0; k < N; k++) begin
                ang = 2.0 * PI * real'(k * n) / real'(N);
                xr  = real'(int'($signed(x[k].re)));
                xi  = real'(int'($signed(x[k].im)));
                sr  = sr + xr * $cos(ang) - xi * $sin(ang);
                si  = si + xr * $sin(ang) + xi * $cos(ang);
            end
            y[n] = mk(int'(sr / real'(N)), int'(si / real'(N)));
        end
        return y;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_near(input string name, input int actual, input int expected, input int tol);
        int d;
        n_checks++;
        d = actual - expected;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, actual, expected, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input bit hold_valid);
        int  k;
        int  guard;
        bit  rdy;
        k     = 0;
        guard = 0;
        while (k < N && guard < 64) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim[k];
            rdy          = bus.in_ready;
            tick();
            if (rdy) k++;
            guard++;
        end
        check("load handshakes", k, N);
        if (hold_valid) bus.in_data = 32'hDEAD_BEEF;
        else            bus.in_valid = 1'b0;
    endtask

    task automatic compute_wait();
        int cyc;
        int leak;
        cyc  = 0;
        leak = 0;
        while (busy && cyc < 100) begin
            if (bus.in_ready) leak++;
            cyc++;
            tick();
        end
        check("busy cycles", cyc, 12);
        check("in_ready during compute", leak, 0);
        check("out_valid low as busy falls", int'(bus.out_valid), 0);
        tick();
        check("out_valid one cycle after busy", int'(bus.out_valid), 1);
    endtask

    task automatic unload_frame(input bit stall);
        int          n, guard, pat, hold_err, last_err, leak;
        bit          prev_stalled;
        logic [31:0] prev_data;
        logic        prev_last;
        bit   [5:0]  pattern;
        pattern      = 6'b101001;
        n            = 0;
        guard        = 0;
        pat          = 0;
        hold_err     = 0;
        last_err     = 0;
        leak         = 0;
        prev_stalled = 1'b0;
        prev_data    = '0;
        prev_last    = 1'b0;
        while (n < N && guard < 200) begin
            bus.out_ready = stall ? pattern[pat] : 1'b1;
            pat = (pat + 1) % 6;
            if (prev_stalled && (bus.out_data !== prev_data || bus.out_last !== prev_last))
                hold_err++;
            if (bus.in_ready) leak++;
            if (bus.out_valid && bus.out_ready) begin
                got[n] = bus.out_data;
                if (bus.out_last !== (n == N - 1)) last_err++;
                n++;
            end
            prev_stalled = bus.out_valid && !bus.out_ready;
            prev_data    = bus.out_data;
            prev_last    = bus.out_last;
            tick();
            guard++;
        end
        check("unload handshakes", n, N);
        check("stall hold errors", hold_err, 0);
        check("out_last placement errors", last_err, 0);
        check("in_ready during unload", leak, 0);
        check("out_valid after last", int'(bus.out_valid), 0);
        check("in_ready after last", int'(bus.in_ready), 1);
    endtask

    task automatic compare_frame(input string name, input frame_t exp_f, input int tol);
        for (int i = 0; i < N; i++) begin
            check_near($sformatf("%s x[%0d].re", name, i),
                       int'($signed(got[i].re)), int'($signed(exp_f[i].re)), tol);
            check_near($sformatf("%s x[%0d].im", name, i),
                       int'($signed(got[i].im)), int'($signed(exp_f[i].im)), tol);
        end
    endtask

    task automatic run_frame(input string name, input frame_t exp_f, input int tol, input bit stall);
        load_frame(1'b0);
        compute_wait();
        unload_frame(stall);
        compare_frame(name, exp_f, tol);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Impulse at bin 0: flat output, exact.
        vecs[0].x_in = '0;
        vecs[0].x_in[0] = mk(16384, 0);
        for (int i = 0; i < N; i++) vecs[0].x_exp[i] = mk(2048, 0);
        vecs[0].tol = 4'd0;
        // Impulse at bin 1: positive rotation, amplitude 2048.
        vecs[1].x_in = '0;
        vecs[1].x_in[1] = mk(16384, 0);
        vecs[1].x_exp[0] = mk(2048, 0);
        vecs[1].x_exp[1] = mk(1448, 1448);
        vecs[1].x_exp[2] = mk(0, 2048);
        vecs[1].x_exp[3] = mk(-1448, 1448);
        vecs[1].x_exp[4] = mk(-2048, 0);
        vecs[1].x_exp[5] = mk(-1448, -1448);
        vecs[1].x_exp[6] = mk(0, -2048);
        vecs[1].x_exp[7] = mk(1448, -1448);
        vecs[1].tol = 4'd2;
        // Full-scale negative DC.
        for (int i = 0; i < N; i++) vecs[2].x_in[i] = mk(-32768, -32768);
        vecs[2].x_exp = '0;
        vecs[2].x_exp[0] = mk(-32768, -32768);
        vecs[2].tol = 4'd0;

        #2 reset_n = 1'b0;
        #1;
        check("reset in_ready", int'(bus.in_ready), 0);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_last", int'(bus.out_last), 0);
        check("reset busy", int'(busy), 0);
        check("reset out_data", int'(bus.out_data), 0);
        tick();
        tick();
        reset_n = 1'b1;

        for (int v = 0; v < 3; v++) begin
            stim = vecs[v].x_in;
            run_frame($sformatf("vec%0d", v), vecs[v].x_exp, int'(vecs[v].tol), 1'b0);
        end

        // Backpressure on the impulse frame.
        stim = vecs[0].x_in;
        run_frame("stall", vecs[0].x_exp, 0, 1'b1);

        // Reset at compute cycle 5, then a clean frame.
        stim = vecs[0].x_in;
        load_frame(1'b0);
        repeat (4) tick();
        check("busy before mid-compute reset", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid reset busy", int'(busy), 0);
        check("mid reset in_ready", int'(bus.in_ready), 0);
        check("mid reset out_valid", int'(bus.out_valid), 0);
        check("mid reset out_data", int'(bus.out_data), 0);
        tick();
        reset_n = 1'b1;
        check("in_ready right after release", int'(bus.in_ready), 0);
        tick();
        tick();
        check("in_ready two cycles after release", int'(bus.in_ready), 1);
        run_frame("after reset", vecs[0].x_exp, 0, 1'b0);

        // Partial load interrupted by reset: next frame must start at bin 0.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234_5678;
        repeat (3) tick();
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        stim = vecs[1].x_in;
        run_frame("after partial", vecs[1].x_exp, 2, 1'b0);

        // Back-to-back frames with in_valid held high throughout.
        bus.out_ready = 1'b1;
        stim = vecs[0].x_in;
        load_frame(1'b1);
        compute_wait();
        unload_frame(1'b0);
        compare_frame("b2b first", vecs[0].x_exp, 0);
        stim = vecs[1].x_in;
        load_frame(1'b0);
        compute_wait();
        unload_frame(1'b0);
        compare_frame("b2b second", vecs[1].x_exp, 2);

        // Random frames against the direct inverse DFT.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++)
                stim[i] = mk(int'($urandom_range(8191, 0)) - 4096,
                             int'($urandom_range(8191, 0)) - 4096);
            expv = ref_idft(stim);
            run_frame($sformatf("rand%0d", f), expv, 6, f[0]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
